// File: rtl/keccak_pkg.sv
// Shared Keccak absorb-path widths: beat width, byte-keep width, rate field and fill counter.
package keccak_pkg;
  parameter int DWIDTH            = 256;
  parameter int KEEP_WIDTH        = 32;
  parameter int RATE_WIDTH        = 11;
  parameter int BYTE_ABSORB_WIDTH = 8;
endpackage

// File: rtl/keccak_absorb_ctrl.sv
// Sequences message beats into the absorb unit, handles block overflow carries,
// padding and permutation hand-offs for one Keccak message at a time.
module keccak_absorb_ctrl
  import keccak_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [RATE_WIDTH-1:0]        rate_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [DWIDTH-1:0]            in_data_i,
  input  logic [KEEP_WIDTH-1:0]        in_keep_i,
  input  logic                         in_last_i,
  output logic [DWIDTH-1:0]            au_msg_o,
  output logic [KEEP_WIDTH-1:0]        au_keep_o,
  output logic [BYTE_ABSORB_WIDTH-1:0] au_bytes_absorbed_o,
  output logic [RATE_WIDTH-1:0]        au_rate_o,
  input  logic [BYTE_ABSORB_WIDTH-1:0] au_bytes_absorbed_i,
  input  logic                         au_has_carry_i,
  input  logic [DWIDTH-1:0]            au_carry_i,
  input  logic [KEEP_WIDTH-1:0]        au_carry_keep_i,
  output logic                         state_we_o,
  output logic                         perm_start_o,
  input  logic                         perm_done_i,
  output logic                         pad_o,
  output logic [BYTE_ABSORB_WIDTH-1:0] pad_pos_o,
  output logic                         done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_PERM,
    S_CARRY,
    S_PAD,
    S_DONE
  } state_t;

  state_t                         state_q;
  logic [RATE_WIDTH-1:0]          rate_q;
  logic [BYTE_ABSORB_WIDTH-1:0]   rate_bytes_q;
  logic [BYTE_ABSORB_WIDTH-1:0]   fill_q;
  logic [DWIDTH-1:0]              carry_q;
  logic [KEEP_WIDTH-1:0]          carry_keep_q;
  logic                           carry_valid_q;
  logic                           last_pending_q;
  logic                           final_q;
  logic                           perm_start_q;
  logic                           pad_q;
  logic                           done_q;

  // Beats are only ever accepted in ABSORB, so a pending carry can never be overrun.
  assign in_ready_o          = (state_q == S_ABSORB);
  assign state_we_o          = (in_ready_o && in_valid_i) || (state_q == S_CARRY);
  assign au_bytes_absorbed_o = fill_q;
  assign au_rate_o           = rate_q;
  assign perm_start_o        = perm_start_q;
  assign pad_o               = pad_q;
  assign pad_pos_o           = pad_q ? fill_q : '0;
  assign done_o              = done_q;

  always_comb begin
    au_msg_o  = '0;
    au_keep_o = '0;
    if (state_q == S_ABSORB) begin
      au_msg_o  = in_data_i;
      au_keep_o = in_keep_i;
    end else if (state_q == S_CARRY) begin
      au_msg_o  = carry_q;
      au_keep_o = carry_keep_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rate_q         <= '0;
      rate_bytes_q   <= '0;
      fill_q         <= '0;
      carry_q        <= '0;
      carry_keep_q   <= '0;
      carry_valid_q  <= 1'b0;
      last_pending_q <= 1'b0;
      final_q        <= 1'b0;
      perm_start_q   <= 1'b0;
      pad_q          <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      perm_start_q <= 1'b0;
      pad_q        <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            rate_q         <= rate_i;
            rate_bytes_q   <= BYTE_ABSORB_WIDTH'(rate_i >> 3);
            fill_q         <= '0;
            carry_q        <= '0;
            carry_keep_q   <= '0;
            carry_valid_q  <= 1'b0;
            last_pending_q <= 1'b0;
            final_q        <= 1'b0;
            state_q        <= S_ABSORB;
          end
        end
        S_ABSORB: begin
          if (in_valid_i) begin
            fill_q <= au_bytes_absorbed_i;
            if (au_has_carry_i) begin
              carry_q        <= au_carry_i;
              carry_keep_q   <= au_carry_keep_i;
              carry_valid_q  <= 1'b1;
              last_pending_q <= in_last_i;
              perm_start_q   <= 1'b1;
              state_q        <= S_PERM;
            end else if (au_bytes_absorbed_i == rate_bytes_q) begin
              last_pending_q <= in_last_i;
              perm_start_q   <= 1'b1;
              state_q        <= S_PERM;
            end else if (in_last_i) begin
              pad_q   <= 1'b1;
              state_q <= S_PAD;
            end
          end
        end
        S_PERM: begin
          if (perm_done_i) begin
            fill_q <= '0;
            if (final_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (carry_valid_q) begin
              state_q <= S_CARRY;
            end else if (last_pending_q) begin
              pad_q   <= 1'b1;
              state_q <= S_PAD;
            end else begin
              state_q <= S_ABSORB;
            end
          end
        end
        // The carry is shorter than any rate, so the absorb-unit carry flag is not consulted here.
        S_CARRY: begin
          fill_q        <= au_bytes_absorbed_i;
          carry_valid_q <= 1'b0;
          if (last_pending_q) begin
            pad_q   <= 1'b1;
            state_q <= S_PAD;
          end else begin
            state_q <= S_ABSORB;
          end
        end
        S_PAD: begin
          final_q      <= 1'b1;
          perm_start_q <= 1'b1;
          state_q      <= S_PERM;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
